// File: rtl/ad9653_tx_pkg.sv
// Shared encodings and frame geometry for the AD9653-style serial LVDS transmitter.
package ad9653_tx_pkg;

  localparam int LANES      = 8;
  localparam int CHANNELS   = 4;
  localparam int FRAME_BITS = 8;

  localparam logic [15:0] ALT_EVEN = 16'hAAAA;
  localparam logic [15:0] ALT_ODD  = 16'h5555;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_FIXED  = 2'd2,
    MODE_ALT    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/ad9653_tx_lane_skew_delay.sv
// One-bit delay line with a selectable 0..7 cycle delay; it keeps shifting at all times.
module lane_skew_delay (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] delay,
  input  logic       din,
  output logic       dout
);

  logic [6:0] dl;
  logic [7:0] taps;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dl <= '0;
    else          dl <= {dl[5:0], din};
  end

  // tap 0 is the undelayed input, tap k is din from k cycles ago
  assign taps = {dl, din};
  assign dout = taps[delay];

endmodule

// File: rtl/ad9653_tx.sv
// Four-channel, two-lane-per-channel serial transmitter with frame clock, test modes
// and per-lane skew/inversion.
module ad9653_tx
  import ad9653_tx_pkg::*;
#(
  parameter logic [7:0]  FLIP_D     = 8'h00,
  parameter bit          FLIP_FRAME = 1'b0,
  parameter logic [23:0] LANE_SKEW  = 24'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] pattern,
  input  logic [63:0] samp_data,
  input  logic        samp_valid,
  output logic        samp_ready,
  output logic [7:0]  tx_lane,
  output logic        tx_fco,
  output logic        frame_start,
  output logic [15:0] underrun_cnt,
  output logic [1:0]  fsm_state
);

  state_t      state, next_state;
  logic [2:0]  bcnt, next_bcnt;
  logic        load, start;
  mode_t       mode_sel;
  logic [15:0] word      [CHANNELS];
  logic [15:0] last_word [CHANNELS];
  logic [FRAME_BITS-1:0] sr [LANES];
  logic [15:0] ramp;
  logic        alt;
  logic [15:0] underrun;
  logic        fco_q, fs_q;

  assign mode_sel = mode_t'(mode);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      bcnt  <= '0;
    end else begin
      state <= next_state;
      bcnt  <= next_bcnt;
    end
  end

  always_comb begin
    next_state = state;
    next_bcnt  = bcnt;
    load       = 1'b0;
    start      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          next_state = ST_LOAD;
          start      = 1'b1;
        end
      end
      ST_LOAD: begin
        load       = 1'b1;
        next_state = ST_SHIFT;
        next_bcnt  = 3'd0;
      end
      ST_SHIFT: begin
        if (bcnt != 3'd7) begin
          next_bcnt = bcnt + 3'd1;
        end else begin
          next_bcnt = 3'd0;
          if (enable) load = 1'b1;
          else        next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_bcnt  = 3'd0;
      end
    endcase
  end

  // Handshake: samp_ready is combinational and high only on a stream-mode load cycle;
  // samp_data is taken at that cycle's clock edge if samp_valid, otherwise it is an underrun.
  assign samp_ready = load && (mode_sel == MODE_STREAM);

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      word[k] = last_word[k];
      case (mode_sel)
        MODE_STREAM: if (samp_valid) word[k] = samp_data[(CHANNELS-1-k)*16 +: 16];
        MODE_RAMP:   word[k] = ramp + 16'(k);
        MODE_FIXED:  word[k] = pattern;
        MODE_ALT:    word[k] = alt ? ALT_ODD : ALT_EVEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LANES; i++) sr[i] <= '0;
      for (int k = 0; k < CHANNELS; k++) last_word[k] <= '0;
      ramp     <= '0;
      alt      <= 1'b0;
      underrun <= '0;
      fco_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      // Shifting in zeros means a finished frame drains to an idle-low lane.
      for (int i = 0; i < LANES; i++) sr[i] <= {sr[i][FRAME_BITS-2:0], 1'b0};
      if (load) begin
        for (int k = 0; k < CHANNELS; k++) begin
          last_word[k]        <= word[k];
          sr[LANES-1-2*k]     <= word[k][15:8];
          sr[LANES-2-2*k]     <= word[k][7:0];
        end
      end
      if (start)                                  ramp <= '0;
      else if (load && mode_sel == MODE_RAMP)     ramp <= ramp + 16'd1;
      if (start)                                  alt  <= 1'b0;
      else if (load && mode_sel == MODE_ALT)      alt  <= ~alt;
      if (load && mode_sel == MODE_STREAM && !samp_valid && underrun != 16'hFFFF)
        underrun <= underrun + 16'd1;
      fco_q <= (next_state == ST_SHIFT) && !next_bcnt[2];
      fs_q  <= (next_state == ST_SHIFT) && (next_bcnt == 3'd0);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic dly;
    lane_skew_delay u_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .delay   (LANE_SKEW[3*i +: 3]),
      .din     (sr[i][FRAME_BITS-1]),
      .dout    (dly)
    );
    assign tx_lane[i] = dly ^ FLIP_D[i];
  end

  assign tx_fco       = fco_q ^ FLIP_FRAME;
  assign frame_start  = fs_q;
  assign underrun_cnt = underrun;
  assign fsm_state    = state;

endmodule

// File: tb/tb_ad9653_tx.sv
// Directed bench for ad9653_tx: a frame monitor rebuilds each frame from the lanes and
// checks it against a queue of expected words; a second instance exercises skew/inversion.
module tb_ad9653_tx;
  import ad9653_tx_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] pattern = 16'h0;
  logic [63:0] samp_data = 64'h0;
  logic        samp_valid = 1'b0;

  logic        samp_ready, tx_fco, frame_start;
  logic [7:0]  tx_lane;
  logic [15:0] underrun_cnt;
  logic [1:0]  fsm_state;

  logic        samp_ready_sk, tx_fco_sk, frame_start_sk;
  logic [7:0]  tx_lane_sk;
  logic [15:0] underrun_cnt_sk;
  logic [1:0]  fsm_state_sk;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  bit          skew_chk = 1'b0;

  logic [63:0] vec_d[$];
  bit          vec_v[$];
  int          vidx = 0;
  logic [63:0] prev_word = 64'h0;

  ad9653_tx dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .pattern(pattern),
    .samp_data(samp_data), .samp_valid(samp_valid), .samp_ready(samp_ready),
    .tx_lane(tx_lane), .tx_fco(tx_fco), .frame_start(frame_start),
    .underrun_cnt(underrun_cnt), .fsm_state(fsm_state)
  );

  ad9653_tx #(.FLIP_D(8'h01), .FLIP_FRAME(1'b1), .LANE_SKEW(24'h000003)) dut_sk (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .pattern(pattern),
    .samp_data(samp_data), .samp_valid(samp_valid), .samp_ready(samp_ready_sk),
    .tx_lane(tx_lane_sk), .tx_fco(tx_fco_sk), .frame_start(frame_start_sk),
    .underrun_cnt(underrun_cnt_sk), .fsm_state(fsm_state_sk)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rep4(input logic [15:0] w);
    return {w, w, w, w};
  endfunction

  // frame monitor / scoreboard
  initial begin : monitor
    logic [7:0]  lb [LANES];
    logic [7:0]  fco_bits;
    logic [63:0] got;
    bit          aborted;
    for (int i = 0; i < LANES; i++) lb[i] = '0;
    fco_bits = '0;
    forever begin
      @(negedge clk);
      if (reset_n && frame_start) begin
        aborted = 1'b0;
        for (int b = 0; b < FRAME_BITS; b++) begin
          if (b > 0) @(negedge clk);
          if (!reset_n) aborted = 1'b1;
          for (int i = 0; i < LANES; i++) lb[i] = {lb[i][6:0], tx_lane[i]};
          fco_bits = {fco_bits[6:0], tx_fco};
        end
        if (!aborted) begin
          got = {lb[7], lb[6], lb[5], lb[4], lb[3], lb[2], lb[1], lb[0]};
          check("frame_fco", {56'h0, fco_bits}, 64'hF0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected act=%h exp=none", got);
          end else begin
            check("frame_data", got, exp_q.pop_front());
          end
        end
      end
    end
  end

  // skewed/inverted instance: lane 0 is lane 2 delayed by 3 and inverted; fco inverted
  initial begin : skew_mon
    logic [2:0] h;
    logic       e_lane, e_fco;
    h = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        h = '0;
      end else begin
        if (skew_chk) begin
          e_lane = ~h[2];
          e_fco  = ~tx_fco;
          check("skew_lane0", {63'h0, tx_lane_sk[0]}, {63'h0, e_lane});
          check("frame_inv", {63'h0, tx_fco_sk}, {63'h0, e_fco});
        end
        h = {h[1:0], tx_lane_sk[2]};
      end
    end
  end

  // stream-mode driver: present the next vector; push its expectation when it is taken
  task automatic drive_stream();
    if (mode == MODE_STREAM && vidx < vec_d.size()) begin
      samp_data  = vec_d[vidx];
      samp_valid = vec_v[vidx];
      #1;
      if (samp_ready) begin
        if (samp_valid) prev_word = samp_data;
        exp_q.push_back(prev_word);
        vidx++;
      end
    end
  endtask

  task automatic run_frames(input int n, input bit chg, input logic [15:0] chg_pat);
    int seen = 0;
    int cyc = 0;
    int last = 0;
    int budget = n * FRAME_BITS + 40;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (frame_start) begin
        seen++;
        if (seen > 1) check("frame_gap", 64'(cyc - last), 64'd8);
        last = cyc;
        if (chg && seen == 1) pattern = chg_pat;
      end
      enable = (seen < n);
      drive_stream();
    end
    if (seen < n) begin
      total++;
      bad++;
      $display("FAIL run_timeout act=%0d exp=%0d", seen, n);
    end
    enable = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_frame_start(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      drive_stream();
      t++;
    end while (!frame_start && t < 30);
    if (!frame_start) begin
      total++;
      bad++;
      $display("FAIL %s act=no_frame_start exp=frame_start", name);
    end
  endtask

  initial begin : stimulus
    bit any_ready;
    int fs_cnt;

    // reset values
    @(negedge clk);
    check("rst_lane", {56'h0, tx_lane}, 64'h00);
    check("rst_fco", {63'h0, tx_fco}, 64'h0);
    check("rst_fs", {63'h0, frame_start}, 64'h0);
    check("rst_ready", {63'h0, samp_ready}, 64'h0);
    check("rst_state", {62'h0, fsm_state}, {62'h0, ST_IDLE});
    check("rst_lane_sk", {56'h0, tx_lane_sk}, 64'h01);
    check("rst_fco_sk", {63'h0, tx_fco_sk}, 64'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    skew_chk = 1'b1;

    // fixed pattern, then a mid-frame pattern change that lands one frame later
    mode = MODE_FIXED;
    pattern = 16'h1234;
    for (int i = 0; i < 3; i++) exp_q.push_back(rep4(16'h1234));
    run_frames(3, 1'b0, 16'h0);
    exp_q.push_back(rep4(16'h1234));
    exp_q.push_back(rep4(16'hBEEF));
    run_frames(2, 1'b1, 16'hBEEF);

    // alternating pattern starts with 0xAAAA
    mode = MODE_ALT;
    exp_q.push_back(rep4(16'hAAAA));
    exp_q.push_back(rep4(16'h5555));
    exp_q.push_back(rep4(16'hAAAA));
    run_frames(3, 1'b0, 16'h0);
    skew_chk = 1'b0;

    // stream, valid always high
    mode = MODE_STREAM;
    vec_d = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'hDEAD_BEEF_CAFE_F00D, 64'h1111_2222_3333_4444};
    vec_v = '{1'b1, 1'b1, 1'b1, 1'b1};
    vidx = 0;
    run_frames(4, 1'b0, 16'h0);
    check("stream_underrun", {48'h0, underrun_cnt}, 64'd0);

    // stream with one missing sample: previous word repeats
    vec_d = '{64'hA5A5_0001_5A5A_0002, 64'h9999_9999_9999_9999, 64'h0F1E_2D3C_4B5A_6978};
    vec_v = '{1'b1, 1'b0, 1'b1};
    vidx = 0;
    run_frames(3, 1'b0, 16'h0);
    check("underrun_one", {48'h0, underrun_cnt}, 64'd1);

    // ramp, and its restart from zero on the next enable
    mode = MODE_RAMP;
    for (int r = 0; r < 2; r++) begin
      for (int f = 0; f < 3 - r; f++)
        exp_q.push_back({16'(f), 16'(f + 1), 16'(f + 2), 16'(f + 3)});
      run_frames(3 - r, 1'b0, 16'h0);
    end

    // enable dropped at bcnt=2: frame completes, no further load
    mode = MODE_STREAM;
    vec_d = '{64'h0F0F_F0F0_3C3C_C3C3};
    vec_v = '{1'b1};
    vidx = 0;
    enable = 1'b1;
    wait_frame_start("drop_start");
    repeat (2) @(negedge clk);
    enable = 1'b0;
    any_ready = 1'b0;
    fs_cnt = 0;
    repeat (14) begin
      @(negedge clk);
      #1;
      any_ready |= samp_ready;
      if (frame_start) fs_cnt++;
    end
    check("drop_ready", {63'h0, any_ready}, 64'h0);
    check("drop_extra_frame", 64'(fs_cnt), 64'd0);
    check("drop_idle", {62'h0, fsm_state}, {62'h0, ST_IDLE});

    // reset mid-frame: everything returns to its reset value immediately
    mode = MODE_FIXED;
    pattern = 16'h5A5A;
    enable = 1'b1;
    wait_frame_start("abort_start");
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    check("abort_lane", {56'h0, tx_lane}, 64'h00);
    check("abort_fco", {63'h0, tx_fco}, 64'h0);
    check("abort_fs", {63'h0, frame_start}, 64'h0);
    check("abort_ready", {63'h0, samp_ready}, 64'h0);
    check("abort_state", {62'h0, fsm_state}, {62'h0, ST_IDLE});
    check("abort_underrun", {48'h0, underrun_cnt}, 64'd0);
    check("abort_lane_sk", {56'h0, tx_lane_sk}, 64'h01);
    check("abort_fco_sk", {63'h0, tx_fco_sk}, 64'h1);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(rep4(16'h5A5A));
    run_frames(1, 1'b0, 16'h0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
